// File: rtl/dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm_access_ctrl
// Purpose  : Data-memory access sequencer; stalls the pipeline across a
//            handshaked bus transaction and formats store/load data.
// Revision : 1.0 - initial release
// ============================================================================
module dm_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  dm_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tmo;
    logic [31:0]      r_rdata;
    logic [1:0]       r_off;
    logic             r_half;
    logic             r_byte;
    logic             r_signed;

    logic        w_access;
    logic        w_half;
    logic        w_byte;
    logic        w_signed;
    logic        w_misaligned;
    logic        w_start;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;
    logic [31:0] w_load;

    assign w_access = mem_read | mem_write;
    assign w_half   = (dm_type == 3'b001) || (dm_type == 3'b010);
    assign w_byte   = (dm_type == 3'b011) || (dm_type == 3'b100);
    assign w_signed = (dm_type == 3'b001) || (dm_type == 3'b011);

    assign w_misaligned = w_byte ? 1'b0 : (w_half ? addr[0] : (addr[1:0] != 2'b00));
    assign w_start      = (r_state == S_IDLE) && w_access && !w_misaligned;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata;
        if (w_byte) begin
            w_be    = 4'b0001 << addr[1:0];
            w_wdata = {4{wdata[7:0]}};
        end else if (w_half) begin
            w_be    = 4'b0011 << {addr[1], 1'b0};
            w_wdata = {2{wdata[15:0]}};
        end
    end

    // Lane selection uses the offset captured at request time, not live addr
    assign w_lane_b = r_rdata[{r_off, 3'b000} +: 8];
    assign w_lane_h = r_off[1] ? r_rdata[31:16] : r_rdata[15:0];

    always_comb begin
        w_load = r_rdata;
        if (r_byte)
            w_load = {{24{r_signed & w_lane_b[7]}}, w_lane_b};
        else if (r_half)
            w_load = {{16{r_signed & w_lane_h[15]}}, w_lane_h};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_REQ;
            S_REQ:   if (bus_ack || (r_cnt == C_CNT_LAST)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        fault = 1'b0;
        rdata = 32'd0;
        case (r_state)
            S_IDLE: begin
                stall = w_access & ~w_misaligned;
                fault = w_access & w_misaligned;
            end
            S_REQ:  stall = 1'b1;
            S_DONE: begin
                fault = r_tmo;
                if (!bus_we && !r_tmo)
                    rdata = w_load;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            r_cnt     <= '0;
            r_tmo     <= 1'b0;
            r_rdata   <= 32'd0;
            r_off     <= 2'd0;
            r_half    <= 1'b0;
            r_byte    <= 1'b0;
            r_signed  <= 1'b0;
        end else begin
            if (w_start) begin
                bus_req   <= 1'b1;
                bus_we    <= mem_write;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_be    <= w_be;
                bus_wdata <= w_wdata;
                r_off     <= addr[1:0];
                r_half    <= w_half;
                r_byte    <= w_byte;
                r_signed  <= w_signed;
                r_cnt     <= '0;
                r_tmo     <= 1'b0;
            end else if (r_state == S_REQ) begin
                if (bus_ack) begin
                    r_rdata <= bus_rdata;
                    bus_req <= 1'b0;
                end else if (r_cnt == C_CNT_LAST) begin
                    bus_req <= 1'b0;
                    r_tmo   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_access_ctrl
// Purpose  : Scoreboard-based self-checking bench for dm_access_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_access_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  dm_type = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        stall;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'd0;
    logic        bus_ack = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic        fault;
        logic [31:0] rdata;
        logic [7:0]  stalls;
        logic [7:0]  reqs;
    } exp_t;
    exp_t exp_q[$];

    dm_access_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .dm_type(dm_type), .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_load(input logic [2:0] t, input logic [1:0] off,
                                           input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w >> (8 * off);
        h = (off >= 2) ? w[31:16] : w[15:0];
        case (t)
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return {16'h0000, h};
            3'd3:    return {{24{b[7]}}, b};
            3'd4:    return {24'h000000, b};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] t, input logic [1:0] off);
        case (t)
            3'd1, 3'd2: return (off >= 2) ? 4'b1100 : 4'b0011;
            3'd3, 3'd4: return 4'(1 << off);
            default:    return 4'b1111;
        endcase
    endfunction

    // Runs one aligned access from its IDLE cycle through DONE; ack_at=0 means never ack.
    task automatic do_access(input string nm, input logic rd, input logic wr,
                             input logic [2:0] t, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] brd,
                             input int ack_at, input logic [3:0] e_be,
                             input logic [31:0] e_bwd, input logic [31:0] e_rd,
                             input logic e_fault);
        exp_t e;
        exp_t got;
        int   stalls = 0;
        int   reqs = 0;
        bit   done = 0;
        e.fault  = e_fault;
        e.rdata  = e_rd;
        e.stalls = 8'(1 + ((ack_at > 0) ? ack_at : TMO));
        e.reqs   = 8'((ack_at > 0) ? ack_at : TMO);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                mem_read = rd; mem_write = wr; dm_type = t; addr = a; wdata = wd;
                exp_q.push_back(e);
            end else begin
                mem_read = 1'b0; mem_write = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0;
                dm_type = 3'd3;
            end
            bus_ack   = bus_req && (reqs + 1 == ack_at);
            bus_rdata = bus_ack ? brd : 32'hDEAD_BEEF;
            #1;
            if (bus_req) begin
                reqs++;
                if (reqs == 1) begin
                    total++;
                    if (bus_addr !== {a[31:2], 2'b00} || bus_be !== e_be || bus_we !== wr ||
                        (wr && bus_wdata !== e_bwd)) begin
                        bad++;
                        $display("FAIL %s bus: addr=%h be=%b we=%b wd=%h, want addr=%h be=%b we=%b wd=%h",
                                 nm, bus_addr, bus_be, bus_we, bus_wdata,
                                 {a[31:2], 2'b00}, e_be, wr, e_bwd);
                    end
                end
            end
            if (stall) begin
                stalls++;
            end else if (c > 0) begin
                done = 1;
                got.fault  = fault;
                got.rdata  = rdata;
                got.stalls = 8'(stalls);
                got.reqs   = 8'(reqs);
                e = exp_q.pop_front();
                total++;
                if (got !== e || bus_req !== 1'b0) begin
                    bad++;
                    $display("FAIL %s done: fault=%b rdata=%h stalls=%0d reqs=%0d req=%b, want fault=%b rdata=%h stalls=%0d reqs=%0d req=0",
                             nm, got.fault, got.rdata, got.stalls, got.reqs, bus_req,
                             e.fault, e.rdata, e.stalls, e.reqs);
                end
            end
        end
        bus_ack = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s no DONE within budget: stalls=%0d want %0d", nm, stalls, e.stalls);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic check_idle(input string nm);
        #1;
        total++;
        if (stall !== 1'b0 || fault !== 1'b0 || rdata !== 32'd0 || bus_req !== 1'b0) begin
            bad++;
            $display("FAIL %s idle: stall=%b fault=%b rdata=%h req=%b, want 0 0 0 0",
                     nm, stall, fault, rdata, bus_req);
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (bus_req !== 0 || bus_we !== 0 || bus_addr !== 0 || bus_be !== 0 || bus_wdata !== 0 ||
            stall !== 0 || fault !== 0 || rdata !== 0) begin
            bad++;
            $display("FAIL reset: req=%b we=%b addr=%h be=%b wd=%h stall=%b fault=%b rdata=%h, want all 0",
                     bus_req, bus_we, bus_addr, bus_be, bus_wdata, stall, fault, rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset_release");
    endtask

    task automatic test_loads();
        do_access("lw", 1, 0, 3'd0, 32'h100, 0, 32'h1234_5678, 2, 4'b1111, 0, 32'h1234_5678, 0);
        do_access("lb", 1, 0, 3'd3, 32'h203, 0, 32'h80AA_BBCC, 1, 4'b1000, 0, 32'hFFFF_FF80, 0);
        do_access("lbu", 1, 0, 3'd4, 32'h203, 0, 32'h80AA_BBCC, 1, 4'b1000, 0, 32'h0000_0080, 0);
        do_access("lh_hi", 1, 0, 3'd1, 32'h302, 0, 32'h9ABC_1234, 3, 4'b1100, 0, 32'hFFFF_9ABC, 0);
        do_access("lhu_lo", 1, 0, 3'd2, 32'h300, 0, 32'h1234_F00D, 1, 4'b0011, 0, 32'h0000_F00D, 0);
        do_access("lw_t7", 1, 0, 3'd7, 32'h404, 0, 32'hCAFE_0001, 1, 4'b1111, 0, 32'hCAFE_0001, 0);
    endtask

    task automatic test_stores();
        do_access("sh", 0, 1, 3'd1, 32'h102, 32'h0000_BEEF, 32'h5555_5555, 1, 4'b1100,
                  32'hBEEF_BEEF, 32'd0, 0);
        do_access("sb", 0, 1, 3'd3, 32'h105, 32'h1234_56A5, 32'h5555_5555, 2, 4'b0010,
                  32'hA5A5_A5A5, 32'd0, 0);
        do_access("sw_rw", 1, 1, 3'd0, 32'h108, 32'h0BAD_F00D, 32'h7777_7777, 1, 4'b1111,
                  32'h0BAD_F00D, 32'd0, 0);
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs[2] = '{32'h101, 32'h103};
        logic [2:0]  types[2] = '{3'd0, 3'd1};
        int          reqs = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_read = 1'b1; dm_type = types[i]; addr = addrs[i];
            #1;
            total++;
            if (fault !== 1'b1 || stall !== 1'b0 || rdata !== 32'd0 || bus_req !== 1'b0) begin
                bad++;
                $display("FAIL misaligned_%0d: fault=%b stall=%b rdata=%h req=%b, want 1 0 0 0",
                         i, fault, stall, rdata, bus_req);
            end
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (c == 1) mem_read = 1'b0;
                #1;
                if (bus_req) reqs++;
            end
        end
        total++;
        if (reqs != 0) begin
            bad++;
            $display("FAIL misaligned_req: bus_req cycles=%0d want 0", reqs);
        end
    endtask

    task automatic test_timeout();
        do_access("timeout", 1, 0, 3'd0, 32'h500, 0, 32'h0, 0, 4'b1111, 0, 32'd0, 1);
        @(negedge clk);
        check_idle("after_timeout");
        do_access("post_timeout", 1, 0, 3'd4, 32'h501, 0, 32'h0000_7F00, 1, 4'b0010, 0,
                  32'h0000_007F, 0);
    endtask

    task automatic test_rst_midway();
        @(negedge clk);
        mem_read = 1'b1; dm_type = 3'd0; addr = 32'h600;
        @(negedge clk);
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_idle("rst_in_req");
        @(negedge clk);
        rst = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        check_idle("late_ack");
        @(negedge clk);
        bus_ack = 1'b0;
        check_idle("after_late_ack");
        do_access("after_rst", 1, 0, 3'd3, 32'h601, 0, 32'h0000_9900, 1, 4'b0010, 0,
                  32'hFFFF_FF99, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [2:0]  t = 3'($urandom_range(0, 4));
            logic [31:0] a = $urandom;
            logic [31:0] w = $urandom;
            int          ak = $urandom_range(1, 3);
            if (t == 3'd0) a[1:0] = 2'b00;
            else if (t <= 3'd2) a[0] = 1'b0;
            do_access("b2b", 1, 0, t, a, 0, w, ak, m_be(t, a[1:0]), 0, m_load(t, a[1:0], w), 0);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_rst_midway();
        test_back_to_back();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: size=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Data-memory access sequencer between the CPU datapath and a handshaked memory bus. It takes the decoded load/store request (read/write, DMType, address, store data) and stalls the pipeline while the bus transaction is in flight. It generates byte enables and lane-replicated store data, and returns sign- or zero-extended load data. Misaligned accesses and bus timeouts are reported as a one-cycle fault.

## Interface
- TIMEOUT, 255: maximum number of REQ cycles without `bus_ack` before the access is aborted; must be ≥1.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_read  in  1  current instruction is a load.
- mem_write  in  1  current instruction is a store; wins if both are high.
- dm_type  in  3  access width/sign:
  - 000 word; 001 half signed; 010 half unsigned; 011 byte signed; 100 byte unsigned.
  - 101–111 are treated as word.
  - Stores use only width: 000, 001, 011.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data; the low byte or half is significant for sb/sh.
- rdata  out  32  extended load data, valid in DONE; 0 otherwise.
- stall  out  1  hold PC and register-file write.
- fault  out  1  one-cycle pulse: misaligned access or timeout.
- bus_req  out  1  transaction request, registered.
- bus_we  out  1  1 = write, registered.
- bus_addr  out  32  `{addr[31:2],2'b00}`, registered.
- bus_be  out  4  byte-lane enables, registered.
- bus_wdata  out  32  lane-replicated store data, registered.
- bus_rdata  in  32  read data, sampled when `bus_ack`=1.
- bus_ack  in  1  transaction complete; 1-cycle pulse.

## Operation
- The FSM has three states:
  - IDLE
    - Access = `mem_read|mem_write`.
    - If access and aligned: stall=1; register the bus_* outputs; bus_req←1; go to REQ.
    - If access and misaligned: fault=1, stall=0, rdata=0, no bus activity, stay in IDLE.
    - Otherwise: stall=0.
  - REQ
    - stall=1; bus_* held stable; wait counter increments each cycle.
    - On `bus_ack`: capture `bus_rdata`; bus_req←0; go to DONE.
    - If counter reaches TIMEOUT-1 with no ack: bus_req←0; set the timeout flag; go to DONE.
  - DONE
    - stall=0 for one cycle so the instruction retires.
    - rdata is valid (0 if timed out).
    - fault=1 if timed out.
    - Next state is IDLE unconditionally.
- Misalignment rules: word with `addr[1:0]≠0`; half with `addr[0]=1`. Bytes are never misaligned.
- Byte enables:
  - byte: `4'b0001<<addr[1:0]`
  - half: `4'b0011<<{addr[1],1'b0}`
  - word: `4'b1111`
  - Loads use the same mask.
- Store data:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata`
- Load extraction uses the captured word and the address offset registered at the IDLE→REQ transition:
  - byte lane = `addr[1:0]`; half lane = `addr[1]`.
  - Extend per dm_type: signed types replicate bit 7/15; unsigned types zero-fill.
- Stores: captured read data is ignored; rdata=0 in DONE.
- `bus_ack` seen in IDLE or DONE is ignored.
- Datapath inputs are sampled only in IDLE; later changes have no effect on the transaction.

## Timing
- Reset values: state=IDLE, all bus_* outputs 0, captured data 0, counter 0, timeout flag 0. With idle inputs, stall=0, fault=0, rdata=0.
- Asserting rst in REQ or DONE returns the FSM to IDLE and drops bus_req immediately. No fault is reported.
- stall and the misalignment fault are combinational from state and inputs.
- rdata is combinational from registered state.
- Latency: IDLE cycle (stall) + N REQ cycles until ack (N≥1) + DONE cycle. An ack in the first REQ cycle gives 3 cycles per memory instruction.
- bus_req rises on the clock edge leaving IDLE and falls on the edge after the ack cycle (or the timeout cycle).
- Timeout: exactly TIMEOUT REQ cycles, then DONE with fault.
- Back-to-back accesses: DONE→IDLE, then the next access starts a fresh IDLE cycle.

## Test plan
- lw, addr=0x100:
  - Stimulus: ack in the 2nd REQ cycle with bus_rdata=0x12345678.
  - Required: bus_addr=0x100, be=1111, we=0; stall high for 3 cycles; in DONE rdata=0x12345678, stall=0.
- lb / lbu, addr=0x203, bus_rdata=0x80AABBCC:
  - lb: be=1000, rdata=0xFFFFFF80.
  - lbu: rdata=0x00000080.
- sh, addr=0x102, wdata=0x0000BEEF:
  - Required: bus_we=1, bus_addr=0x100, be=1100, bus_wdata=0xBEEFBEEF; rdata=0 in DONE.
- lw, addr=0x101:
  - Required: fault=1 and stall=0 in the same cycle; bus_req never asserted; lh at 0x103 behaves the same.
- TIMEOUT=4, no ack:
  - Required: bus_req high exactly 4 cycles; DONE with fault=1, rdata=0; then IDLE.
- rst asserted in the 2nd REQ cycle:
  - Required: bus_req=0, stall=0 before the next clock edge; a late ack is ignored; the next access runs normally.
